// File: rtl/cache_pkg.sv
// cache_pkg -- shared definitions for the cache_dados data cache.
//   * default geometry (ADDR_W / DATA_W / INDEX_W)
//   * FSM state encoding
//   * tag/index slicing helpers (word address = {tag, index})
package cache_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 32;
  localparam int INDEX_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // The line index is the low INDEX_W bits of the word address.
  function automatic logic [31:0] index_of(input logic [31:0] addr, input int index_w);
    return addr & ((32'd1 << index_w) - 32'd1);
  endfunction

  // The tag is everything above the index.
  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int index_w);
    return addr >> index_w;
  endfunction

endpackage

// File: rtl/cache_dados_array.sv
// cache_dados_array -- line storage for the direct-mapped cache.
// One word per line. Reads are asynchronous on 'index'; one write port
// updates every field of the addressed line on the rising clock edge.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears valid/dirty)
//   index           line selected for both read and write
//   we              write strobe for the selected line
//   w_tag/w_data/w_valid/w_dirty   new contents of the line
//   rd_tag/rd_data/rd_valid/rd_dirty  current contents of the line
module cache_dados_array #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               we,
  input  logic [TAG_W-1:0]   w_tag,
  input  logic [DATA_W-1:0]  w_data,
  input  logic               w_valid,
  input  logic               w_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               rd_dirty
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[index] <= w_valid;
      dirty_q[index] <= w_dirty;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; a cleared valid
  // bit makes their contents irrelevant and keeps them mappable to RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[index]  <= w_tag;
      data_mem[index] <= w_data;
    end
  end

  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];

endmodule

// File: rtl/cache_dados.sv
// cache_dados -- direct-mapped, write-back, write-allocate data cache
// between the MIPS Memory stage and main data memory (one word per line).
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   address, data            core word address / store data (stable while stall)
//   r_en, w_en               core load / store request (store wins if both)
//   stall                    registered, high while a request is in progress
//   saida_cache              registered load data, valid when stall falls
//   mem_address              main-memory word address
//   mem_data_out             write-back data
//   mem_r_en, mem_w_en       memory read / write request, held until mem_ready
//   mem_data_in, mem_ready   refill data and one-cycle completion strobe
//   hit_count, miss_count    (CACHE_STATS_EN only) first-visit COMPARE outcomes
module cache_dados
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              r_en,
  input  logic              w_en,
  output logic              stall,
  output logic [DATA_W-1:0] saida_cache,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_r_en,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t             state;
  logic               op_store;
  logic               refill;    // set while re-entering COMPARE after a refill
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag_cur;

  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               rd_dirty;
  logic               hit;

  logic               arr_we;
  logic [TAG_W-1:0]   w_tag;
  logic [DATA_W-1:0]  w_data;
  logic               w_valid;
  logic               w_dirty;

  assign idx     = INDEX_W'(index_of(32'(address), INDEX_W));
  assign tag_cur = TAG_W'(tag_of(32'(address), INDEX_W));
  assign hit     = rd_valid && (rd_tag == tag_cur);

  cache_dados_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .index    (idx),
    .we       (arr_we),
    .w_tag    (w_tag),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .w_dirty  (w_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty)
  );

  // Line update: store hit, write-back completion, or refill completion.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    arr_we  = 1'b0;
    w_tag   = rd_tag;
    w_data  = rd_data;
    w_valid = rd_valid;
    w_dirty = rd_dirty;
    unique case (state)
      COMPARE: if (hit && op_store) begin
        arr_we  = 1'b1;
        w_data  = data;
        w_valid = 1'b1;
        w_dirty = 1'b1;
      end
      WRITEBACK: if (mem_ready) begin
        arr_we  = 1'b1;
        w_dirty = 1'b0;
      end
      ALLOCATE: if (mem_ready) begin
        arr_we  = 1'b1;
        w_tag   = tag_cur;
        w_data  = mem_data_in;
        w_valid = 1'b1;
        w_dirty = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_store     <= 1'b0;
      refill       <= 1'b0;
      stall        <= 1'b0;
      saida_cache  <= '0;
      mem_address  <= '0;
      mem_data_out <= '0;
      mem_r_en     <= 1'b0;
      mem_w_en     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (r_en || w_en) begin
          op_store <= w_en;   // store wins when both are requested
          stall    <= 1'b1;
          state    <= COMPARE;
        end
        COMPARE: if (hit) begin
          if (!op_store) saida_cache <= rd_data;
          stall  <= 1'b0;
          refill <= 1'b0;
          state  <= IDLE;
        end else begin
          refill <= 1'b1;
          if (rd_valid && rd_dirty) begin
            mem_w_en     <= 1'b1;
            mem_address  <= {rd_tag, idx};
            mem_data_out <= rd_data;
            state        <= WRITEBACK;
          end else begin
            mem_r_en    <= 1'b1;
            mem_address <= address;
            state       <= ALLOCATE;
          end
        end
        WRITEBACK: if (mem_ready) begin
          mem_w_en    <= 1'b0;
          mem_r_en    <= 1'b1;
          mem_address <= address;
          state       <= ALLOCATE;
        end
        ALLOCATE: if (mem_ready) begin
          mem_r_en <= 1'b0;
          state    <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Only the first COMPARE of a request is an outcome; the post-refill
  // re-compare always hits and is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == COMPARE && !refill) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_dados.sv
// tb_cache_dados -- directed self-checking bench for cache_dados.
// A behavioural main memory answers mem_r_en/mem_w_en with a one-cycle
// mem_ready after a programmable delay and logs every transfer.
module tb_cache_dados;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] address;
  logic [31:0] data;
  logic        r_en;
  logic        w_en;
  logic        stall;
  logic [31:0] saida_cache;
  logic [11:0] mem_address;
  logic [31:0] mem_data_out;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_data_in;
  logic        mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_dados dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .data         (data),
    .r_en         (r_en),
    .w_en         (w_en),
    .stall        (stall),
    .saida_cache  (saida_cache),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural main memory ----------------
  logic [31:0] mem [4096];
  int          mem_delay   = 0;
  int          rd_count    = 0;
  int          wr_count    = 0;
  logic [11:0] last_rd_addr = '0;
  logic [11:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        both_high   = 1'b0;

  initial begin
    int cnt;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    mem[12'h010] = 32'hDEAD_BEEF;
    mem[12'h020] = 32'hCAFE_F00D;
    mem_ready   = 1'b0;
    mem_data_in = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_r_en && mem_w_en) both_high = 1'b1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (rst) begin
        cnt = 0;
      end else if (mem_r_en || mem_w_en) begin
        if (cnt >= mem_delay) begin
          mem_ready = 1'b1;
          if (mem_r_en) begin
            mem_data_in  = mem[mem_address];
            last_rd_addr = mem_address;
            rd_count++;
          end else begin
            mem[mem_address] = mem_data_out;
            last_wr_addr = mem_address;
            last_wr_data = mem_data_out;
            wr_count++;
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // Issue one request from a negedge and wait (bounded) for stall to fall.
  // Returns the number of sampled cycles stall was high.
  task automatic access(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [31:0] d, output int cycles);
    address = a;
    data    = d;
    r_en    = rd;
    w_en    = wr;
    cycles  = 0;
    @(negedge clk);
    while (stall && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 200) check("stall_timeout", 32'(cycles), 32'd0);
    r_en = 1'b0;
    w_en = 1'b0;
  endtask

  initial begin
    int cyc;
    int rd0, wr0;
    rst = 1'b1; address = '0; data = '0; r_en = 1'b0; w_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_stall",  32'(stall), 32'd0);
    check("rst_saida",  saida_cache, 32'd0);
    check("rst_mem_r",  32'(mem_r_en), 32'd0);
    check("rst_mem_w",  32'(mem_w_en), 32'd0);
    check("rst_mem_a",  32'(mem_address), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss on 0x010: COMPARE, ALLOCATE (1-cycle ready), COMPARE -> 3 stall cycles
    access(1'b1, 1'b0, 12'h010, '0, cyc);
    check("miss_data",   saida_cache, 32'hDEAD_BEEF);
    check("miss_rdaddr", 32'(last_rd_addr), 32'h010);
    check("miss_cycles", 32'(cyc), 32'd3);

    // Hit on 0x010: stall high for exactly 1 cycle
    access(1'b1, 1'b0, 12'h010, '0, cyc);
    check("hit_cycles", 32'(cyc), 32'd1);
    check("hit_data",   saida_cache, 32'hDEAD_BEEF);

    // Store hit: no memory traffic, load data register untouched
    wr0 = wr_count;
    access(1'b0, 1'b1, 12'h010, 32'h0000_1234, cyc);
    check("st_cycles",  32'(cyc), 32'd1);
    check("st_no_wr",   32'(wr_count), 32'(wr0));
    check("st_hold",    saida_cache, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 12'h010, '0, cyc);
    check("st_readback", saida_cache, 32'h0000_1234);

    // Conflict miss on 0x020 with dirty 0x010: write-back, then refill
    wr0 = wr_count;
    access(1'b1, 1'b0, 12'h020, '0, cyc);
    check("wb_count",  32'(wr_count - wr0), 32'd1);
    check("wb_addr",   32'(last_wr_addr), 32'h010);
    check("wb_data",   last_wr_data, 32'h0000_1234);
    check("wb_rdaddr", 32'(last_rd_addr), 32'h020);
    check("wb_fill",   saida_cache, 32'hCAFE_F00D);

    // Delayed refill of 0x030 (clean victim): outputs stable until mem_ready
    mem_delay = 5;
    address = 12'h030; r_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_r_en && cyc < 20);
    for (int k = 0; k < 5; k++) begin
      check("dly_mem_r",  32'(mem_r_en), 32'd1);
      check("dly_stall",  32'(stall), 32'd1);
      check("dly_addr",   32'(mem_address), 32'h030);
      check("dly_no_rdy", 32'(mem_ready), 32'd0);
      @(negedge clk);
    end
    cyc = 0;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("dly_done", 32'(stall), 32'd0);
    r_en = 1'b0;
    check("dly_data", saida_cache, 32'h1000_0030);
    mem_delay = 0;

    // Dirty 0x030, then reset in the middle of its write-back
    access(1'b0, 1'b1, 12'h030, 32'h0000_AAAA, cyc);
    mem_delay = 1000;
    wr0 = wr_count;
    address = 12'h040; r_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_w_en && cyc < 20);
    check("rwb_entered", 32'(mem_w_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rwb_mem_w", 32'(mem_w_en), 32'd0);
    check("rwb_mem_r", 32'(mem_r_en), 32'd0);
    check("rwb_stall", 32'(stall), 32'd0);
    r_en = 1'b0;
    @(negedge clk);
    check("rwb_no_wr", 32'(wr_count), 32'(wr0));
`ifdef CACHE_STATS_EN
    check("rwb_hits",   hit_count, 32'd0);
    check("rwb_misses", miss_count, 32'd0);
`endif
    rst = 1'b0;
    mem_delay = 0;
    @(negedge clk);

    // valid was cleared: 0x010 misses and refills without any write-back
    rd0 = rd_count; wr0 = wr_count;
    access(1'b1, 1'b0, 12'h010, '0, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd3);
    check("post_rst_rd",     32'(rd_count - rd0), 32'd1);
    check("post_rst_no_wr",  32'(wr_count), 32'(wr0));
    check("post_rst_data",   saida_cache, 32'h0000_1234);

    // r_en and w_en together: store of 0x55 to 0x003 (write-allocate)
    access(1'b1, 1'b1, 12'h003, 32'h0000_0055, cyc);
    check("both_hold",   saida_cache, 32'h0000_1234);
    check("both_rdaddr", 32'(last_rd_addr), 32'h003);
    access(1'b1, 1'b0, 12'h003, '0, cyc);
    check("both_cycles", 32'(cyc), 32'd1);
    check("both_load",   saida_cache, 32'h0000_0055);
    check("both_no_wr",  32'(wr_count), 32'(wr0));

`ifdef CACHE_STATS_EN
    check("stat_hits",   hit_count, 32'd1);
    check("stat_misses", miss_count, 32'd2);
`endif
    check("never_both_en", 32'(both_high), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
